// File: rtl/fios_sched_pkg.sv
// fios_sched_pkg
// Shared word type and FSM state encoding for the FIOS Montgomery
// multiplier job scheduler and its word buffers.
// Build option used elsewhere: FIOS_SCHED_PERF_CNT_EN (RUN cycle counter).
package fios_sched_pkg;

    localparam int WORD_W = 17;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        LOAD,
        START,
        RUN,
        DRAIN
    } sched_state_t;

endpackage

// File: rtl/fios_word_buffer.sv
// fios_word_buffer
// DEPTH-entry buffer of 17-bit words with one synchronous write port, one
// combinational read port and a WIN-word combinational window read whose
// words beyond the end of the buffer read as zero.
// Ports:
//   clock_i          clock
//   we_i/waddr_i/wdata_i  synchronous write port
//   raddr_i/rdata_o  combinational single-word read
//   wbase_i/win_o    window read, word k = mem[wbase_i+k] or 0 past the end
module fios_word_buffer
    import fios_sched_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIN   = 1,
    parameter int BW    = 4
) (
    input  logic                     clock_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WORD_W-1:0]        wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WORD_W-1:0]        rdata_o,
    input  logic [BW-1:0]            wbase_i,
    output logic [WIN*WORD_W-1:0]    win_o
);

    localparam int AW = $clog2(DEPTH);

    word_t mem_q [DEPTH];

    // Storage has no reset: contents survive a scheduler reset and are
    // simply overwritten by the next job.
    always_ff @(posedge clock_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

    // Window read zero-fills every slot that falls past the last word so the
    // final, partial FOLD window carries zeros in its upper PEs.
    always_comb begin
        win_o = '0;
        for (int k = 0; k < WIN; k++) begin
            if (int'(wbase_i) + k < DEPTH) begin
                win_o[k*WORD_W +: WORD_W] = mem_q[AW'(int'(wbase_i) + k)];
            end
        end
    end

endmodule

// File: rtl/fios_mm_scheduler.sv
// fios_mm_scheduler
// Job sequencer between a host word stream and one FIOS Montgomery
// multiplier (EXPAND: PE_NB == s, FOLD: PE_NB < s). Loads a, b, p
// (s words each, LSW first), pulses mm_start_o, serves a windows and b/p
// words on multiplier strobes, captures s result words and streams them
// back to the host with valid/ready.
// Ports:
//   clock_i, reset_i (synchronous, active high)
//   p_prime_0_i                  Montgomery constant, latched on first word
//   in_valid_i/in_ready_o/in_data_i      operand stream
//   out_valid_o/out_ready_i/out_data_o/out_last_o  result stream
//   busy_o, err_o                status (err_o sticky per job)
//   mm_start_o, mm_p_prime_0_o, mm_a_o, mm_b_o, mm_p_o  to multiplier
//   mm_a_shift_i, mm_b_fetch_i, mm_p_fetch_i, mm_res_push_i, mm_done_i,
//   mm_res_i                     from multiplier
// Build option: FIOS_SCHED_PERF_CNT_EN adds cycles_o, a saturating count of
// RUN cycles for the most recent job.
module fios_mm_scheduler
    import fios_sched_pkg::*;
#(
    parameter int s     = 8,
    parameter int PE_NB = 8
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic [WORD_W-1:0]         p_prime_0_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [WORD_W-1:0]         in_data_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [WORD_W-1:0]         out_data_o,
    output logic                      out_last_o,
    output logic                      busy_o,
    output logic                      err_o,
    output logic                      mm_start_o,
    output logic [WORD_W-1:0]         mm_p_prime_0_o,
    output logic [PE_NB*WORD_W-1:0]   mm_a_o,
    output logic [WORD_W-1:0]         mm_b_o,
    output logic [WORD_W-1:0]         mm_p_o,
    input  logic                      mm_a_shift_i,
    input  logic                      mm_b_fetch_i,
    input  logic                      mm_p_fetch_i,
    input  logic                      mm_res_push_i,
    input  logic                      mm_done_i,
    input  logic [WORD_W-1:0]         mm_res_i
`ifdef FIOS_SCHED_PERF_CNT_EN
    , output logic [31:0]             cycles_o
`endif
);

    localparam int PW  = $clog2(s);
    localparam int WCW = $clog2(3*s);
    localparam int RCW = $clog2(s+1);
    localparam int ABW = $clog2(s+PE_NB);

    sched_state_t      state_q;
    logic [WCW-1:0]    wc_q;
    logic [PW-1:0]     b_ptr_q;
    logic [PW-1:0]     p_ptr_q;
    logic [PW-1:0]     oc_q;
    logic [ABW-1:0]    a_base_q;
    logic [RCW-1:0]    rc_q;
    logic [RCW-1:0]    rc_d;
    logic              err_q;
    logic              err_d;
    logic [WORD_W-1:0] pp0_q;

    logic accept;
    logic strobe_any;
    logic res_ok;
    logic a_we;
    logic b_we;
    logic p_we;
    logic r_we;

    logic [PE_NB*WORD_W-1:0] a_win;
    logic [WORD_W-1:0]       a_rd_unused;
    logic [WORD_W-1:0]       b_rd;
    logic [WORD_W-1:0]       p_rd;
    logic [WORD_W-1:0]       r_rd;
    logic [WORD_W-1:0]       unusedBWin;
    logic [WORD_W-1:0]       unusedPWin;
    logic [WORD_W-1:0]       unusedRWin;

    assign accept     = (state_q == LOAD) && in_valid_i;
    assign strobe_any = mm_a_shift_i | mm_b_fetch_i | mm_p_fetch_i | mm_res_push_i | mm_done_i;
    assign res_ok     = mm_res_push_i && (rc_q != RCW'(s));

    assign a_we = accept && (wc_q < WCW'(s));
    assign b_we = accept && (wc_q >= WCW'(s)) && (wc_q < WCW'(2*s));
    assign p_we = accept && (wc_q >= WCW'(2*s));
    assign r_we = (state_q == RUN) && res_ok;

    fios_word_buffer #(.DEPTH(s), .WIN(PE_NB), .BW(ABW)) u_a_buf (
        .clock_i (clock_i),
        .we_i    (a_we),
        .waddr_i (PW'(wc_q)),
        .wdata_i (in_data_i),
        .raddr_i ('0),
        .rdata_o (a_rd_unused),
        .wbase_i (a_base_q),
        .win_o   (a_win)
    );

    fios_word_buffer #(.DEPTH(s), .WIN(1), .BW(1)) u_b_buf (
        .clock_i (clock_i),
        .we_i    (b_we),
        .waddr_i (PW'(wc_q - WCW'(s))),
        .wdata_i (in_data_i),
        .raddr_i (b_ptr_q),
        .rdata_o (b_rd),
        .wbase_i (1'b0),
        .win_o   (unusedBWin)
    );

    fios_word_buffer #(.DEPTH(s), .WIN(1), .BW(1)) u_p_buf (
        .clock_i (clock_i),
        .we_i    (p_we),
        .waddr_i (PW'(wc_q - WCW'(2*s))),
        .wdata_i (in_data_i),
        .raddr_i (p_ptr_q),
        .rdata_o (p_rd),
        .wbase_i (1'b0),
        .win_o   (unusedPWin)
    );

    fios_word_buffer #(.DEPTH(s), .WIN(1), .BW(1)) u_r_buf (
        .clock_i (clock_i),
        .we_i    (r_we),
        .waddr_i (PW'(rc_q)),
        .wdata_i (mm_res_i),
        .raddr_i (oc_q),
        .rdata_o (r_rd),
        .wbase_i (1'b0),
        .win_o   (unusedRWin)
    );

    // Result count after this cycle's push; a push at a full buffer is dropped.
    // Error flag: START restarts it, RUN flags overflow or a short result,
    // and any multiplier strobe outside RUN is a protocol error.
    always_comb begin
        rc_d  = rc_q + RCW'(res_ok);
        err_d = err_q | strobe_any;
        case (state_q)
            START:   err_d = strobe_any;
            RUN:     err_d = err_q | (mm_res_push_i & ~res_ok) | (mm_done_i & (rc_d != RCW'(s)));
            default: err_d = err_q | strobe_any;
        endcase
    end

    // Job FSM. Strobes in the mm_done_i cycle are applied before leaving RUN.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= LOAD;
            wc_q     <= '0;
            b_ptr_q  <= '0;
            p_ptr_q  <= '0;
            oc_q     <= '0;
            a_base_q <= '0;
            rc_q     <= '0;
            err_q    <= 1'b0;
            pp0_q    <= '0;
        end else begin
            err_q <= err_d;
            case (state_q)
                LOAD: begin
                    if (in_valid_i) begin
                        if (wc_q == '0) begin
                            pp0_q <= p_prime_0_i;
                        end
                        if (wc_q == WCW'(3*s-1)) begin
                            wc_q    <= '0;
                            state_q <= START;
                        end else begin
                            wc_q <= wc_q + WCW'(1);
                        end
                    end
                end
                START: begin
                    b_ptr_q  <= '0;
                    p_ptr_q  <= '0;
                    oc_q     <= '0;
                    a_base_q <= '0;
                    rc_q     <= '0;
                    state_q  <= RUN;
                end
                RUN: begin
                    if (mm_b_fetch_i) begin
                        b_ptr_q <= (b_ptr_q == PW'(s-1)) ? '0 : b_ptr_q + PW'(1);
                    end
                    if (mm_p_fetch_i) begin
                        p_ptr_q <= (p_ptr_q == PW'(s-1)) ? '0 : p_ptr_q + PW'(1);
                    end
                    // Once the window is past the operand it reads all zeros;
                    // holding the base keeps it inside its width.
                    if (mm_a_shift_i && (a_base_q < ABW'(s))) begin
                        a_base_q <= a_base_q + ABW'(PE_NB);
                    end
                    rc_q <= rc_d;
                    if (mm_done_i) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_ready_i) begin
                        if (oc_q == PW'(s-1)) begin
                            oc_q    <= '0;
                            wc_q    <= '0;
                            state_q <= LOAD;
                        end else begin
                            oc_q <= oc_q + PW'(1);
                        end
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

`ifdef FIOS_SCHED_PERF_CNT_EN
    logic [31:0] cycles_q;

    // RUN cycle counter, cleared at START and held until the next job.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cycles_q <= '0;
        end else if (state_q == START) begin
            cycles_q <= '0;
        end else if ((state_q == RUN) && (cycles_q != 32'hFFFF_FFFF)) begin
            cycles_q <= cycles_q + 32'd1;
        end
    end

    assign cycles_o = cycles_q;
`endif

    // All handshake and status outputs decode registered state only. The
    // operand paths read as zero in LOAD so stale buffers never leak out.
    assign in_ready_o     = (state_q == LOAD);
    assign busy_o         = (state_q != LOAD);
    assign mm_start_o     = (state_q == START);
    assign out_valid_o    = (state_q == DRAIN);
    assign out_last_o     = (state_q == DRAIN) && (oc_q == PW'(s-1));
    assign out_data_o     = (state_q == DRAIN) ? r_rd : '0;
    assign err_o          = err_q;
    assign mm_p_prime_0_o = pp0_q;
    assign mm_a_o         = (state_q == LOAD) ? '0 : a_win;
    assign mm_b_o         = (state_q == LOAD) ? '0 : b_rd;
    assign mm_p_o         = (state_q == LOAD) ? '0 : p_rd;

endmodule

// File: tb/tb_fios_mm_scheduler.sv
// tb_fios_mm_scheduler
// Directed bench for fios_mm_scheduler. Two instances share all stimulus:
// dutF is a FOLD build (s=8, PE_NB=3) and carries most checks; dutE is an
// EXPAND build (s=8, PE_NB=8) used for its full-width a window. The bench
// plays both the host and the multiplier.
module tb_fios_mm_scheduler;

    logic        clock;
    logic        reset;
    logic        inValid;
    logic        outReady;
    logic        mmShift;
    logic        mmBFetch;
    logic        mmPFetch;
    logic        mmPush;
    logic        mmDone;
    logic [16:0] pPrime0;
    logic [16:0] inData;
    logic [16:0] mmRes;

    logic        inReady, outValid, outLast, busy, err, mmStart;
    logic [16:0] outData, mmPP, mmB, mmP;
    logic [50:0] mmAF;

    logic        eInReady, eOutValid, eOutLast, eBusy, eErr, eMmStart;
    logic [16:0] eOutData, eMmPP, eMmB, eMmP;
    logic [135:0] mmAE;

`ifdef FIOS_SCHED_PERF_CNT_EN
    logic [31:0] cyclesF, cyclesE;
`endif

    logic [16:0] aW [8];
    logic [16:0] bW [8];
    logic [16:0] pW [8];
    logic [16:0] rW [8];

    int checkCount = 0;
    int errorCount = 0;

    fios_mm_scheduler #(.s(8), .PE_NB(3)) dutF (
        .clock_i(clock), .reset_i(reset), .p_prime_0_i(pPrime0),
        .in_valid_i(inValid), .in_ready_o(inReady), .in_data_i(inData),
        .out_valid_o(outValid), .out_ready_i(outReady), .out_data_o(outData),
        .out_last_o(outLast), .busy_o(busy), .err_o(err), .mm_start_o(mmStart),
        .mm_p_prime_0_o(mmPP), .mm_a_o(mmAF), .mm_b_o(mmB), .mm_p_o(mmP),
        .mm_a_shift_i(mmShift), .mm_b_fetch_i(mmBFetch), .mm_p_fetch_i(mmPFetch),
        .mm_res_push_i(mmPush), .mm_done_i(mmDone), .mm_res_i(mmRes)
`ifdef FIOS_SCHED_PERF_CNT_EN
        , .cycles_o(cyclesF)
`endif
    );

    fios_mm_scheduler #(.s(8), .PE_NB(8)) dutE (
        .clock_i(clock), .reset_i(reset), .p_prime_0_i(pPrime0),
        .in_valid_i(inValid), .in_ready_o(eInReady), .in_data_i(inData),
        .out_valid_o(eOutValid), .out_ready_i(outReady), .out_data_o(eOutData),
        .out_last_o(eOutLast), .busy_o(eBusy), .err_o(eErr), .mm_start_o(eMmStart),
        .mm_p_prime_0_o(eMmPP), .mm_a_o(mmAE), .mm_b_o(eMmB), .mm_p_o(eMmP),
        .mm_a_shift_i(mmShift), .mm_b_fetch_i(mmBFetch), .mm_p_fetch_i(mmPFetch),
        .mm_res_push_i(mmPush), .mm_done_i(mmDone), .mm_res_i(mmRes)
`ifdef FIOS_SCHED_PERF_CNT_EN
        , .cycles_o(cyclesE)
`endif
    );

    // Free-running 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [135:0] actual, input logic [135:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 unit after the edge.
    task automatic applyStimulus();
        @(posedge clock);
        #1;
    endtask

    // Streams a, b, p into the scheduler and checks the start pulse timing.
    // p_prime_0_i changes after the first word to prove it is latched there.
    task automatic loadJob(input logic [16:0] pp, input logic errBefore);
        for (int i = 0; i < 24; i++) begin
            pPrime0 = (i == 0) ? pp : ~pp;
            inValid = 1'b1;
            inData  = (i < 8) ? aW[i] : (i < 16) ? bW[i-8] : pW[i-16];
            if (i == 23) checkOutput("startBeforeLastAccept", mmStart, 0);
            applyStimulus();
        end
        inValid = 1'b0;
        checkOutput("startPulse", mmStart, 1);
        checkOutput("readyLowInStart", inReady, 0);
        checkOutput("errHeldIntoStart", err, errBefore);
        checkOutput("pPrimeLatched", mmPP, pp);
        applyStimulus();
        checkOutput("startOneCycle", mmStart, 0);
        checkOutput("busyInRun", busy, 1);
        checkOutput("errClearedByStart", err, 0);
    endtask

    // Multiplier side: push n result words, optionally with done on the last.
    task automatic pushWords(input int n, input bit doneWithLast);
        for (int i = 0; i < n; i++) begin
            mmPush = 1'b1;
            mmRes  = rW[i];
            mmDone = doneWithLast && (i == n - 1);
            applyStimulus();
        end
        mmPush = 1'b0;
        mmDone = 1'b0;
    endtask

    // Host side: drain all eight words with out_ready_i held high.
    task automatic drainAll();
        for (int i = 0; i < 8; i++) begin
            checkOutput("outValid", outValid, 1);
            checkOutput("outData", outData, rW[i]);
            checkOutput("outLast", outLast, (i == 7));
            outReady = 1'b1;
            applyStimulus();
        end
        outReady = 1'b0;
        checkOutput("backInLoad", inReady, 1);
        checkOutput("validDropped", outValid, 0);
    endtask

    initial begin
        reset    = 1'b1;
        inValid  = 1'b0;
        outReady = 1'b0;
        mmShift  = 1'b0;
        mmBFetch = 1'b0;
        mmPFetch = 1'b0;
        mmPush   = 1'b0;
        mmDone   = 1'b0;
        pPrime0  = 17'h0;
        inData   = 17'h0;
        mmRes    = 17'h0;

        // Reset values.
        applyStimulus();
        applyStimulus();
        checkOutput("rstInReady", inReady, 1);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstStart", mmStart, 0);
        checkOutput("rstOutValid", outValid, 0);
        checkOutput("rstOutLast", outLast, 0);
        checkOutput("rstOutData", outData, 0);
        checkOutput("rstErr", err, 0);
        checkOutput("rstPPrime", mmPP, 0);
        checkOutput("rstA", mmAF, 0);
        checkOutput("rstB", mmB, 0);
        checkOutput("rstP", mmP, 0);
        reset = 1'b0;

        // Job 1: a=1, b=1, p=2^136-1. R = 2^136 = 1 mod p, so a*b*R^-1 mod p = 1.
        for (int i = 0; i < 8; i++) begin
            aW[i] = (i == 0) ? 17'h1 : 17'h0;
            bW[i] = (i == 0) ? 17'h1 : 17'h0;
            pW[i] = 17'h1FFFF;
            rW[i] = (i == 0) ? 17'h1 : 17'h0;
        end
        loadJob(17'h00001, 1'b0);
        checkOutput("job1B0", mmB, 17'h1);
        pushWords(8, 1'b1);
        checkOutput("job1Err", err, 0);
        drainAll();

        // Job 2: distinct operands for window, wrap and stall checks.
        for (int i = 0; i < 8; i++) begin
            aW[i] = 17'h001A0 + 17'(i);
            bW[i] = 17'h002B0 + 17'(i);
            pW[i] = 17'h003C0 + 17'(i);
            rW[i] = 17'h0A000 + 17'(i * 'h111);
        end
        loadJob(17'h15555, 1'b0);
        checkOutput("winF0", mmAF, {aW[2], aW[1], aW[0]});
        checkOutput("winE0", mmAE, {aW[7], aW[6], aW[5], aW[4], aW[3], aW[2], aW[1], aW[0]});
        mmShift = 1'b1; applyStimulus(); mmShift = 1'b0;
        checkOutput("winF1", mmAF, {aW[5], aW[4], aW[3]});
        checkOutput("winE1", mmAE, 0);
        mmShift = 1'b1; applyStimulus(); mmShift = 1'b0;
        checkOutput("winF2", mmAF, {17'h0, aW[7], aW[6]});
        mmShift = 1'b1; applyStimulus(); mmShift = 1'b0;
        checkOutput("winF3", mmAF, 0);
        checkOutput("winE3", mmAE, 0);

        checkOutput("bStart", mmB, bW[0]);
        checkOutput("pStart", mmP, pW[0]);
        for (int j = 0; j < 9; j++) begin
            mmBFetch = 1'b1;
            mmPFetch = (j < 2);
            applyStimulus();
            mmBFetch = 1'b0;
            mmPFetch = 1'b0;
            checkOutput("bFetchWrap", mmB, bW[(j + 1) % 8]);
        end
        checkOutput("pIndependent", mmP, pW[2]);

        pushWords(8, 1'b0);
        mmDone = 1'b1; applyStimulus(); mmDone = 1'b0;
        checkOutput("job2Err", err, 0);
        checkOutput("job2Busy", busy, 1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("preStallData", outData, rW[i]);
            outReady = 1'b1;
            applyStimulus();
        end
        outReady = 1'b0;
        for (int c = 0; c < 5; c++) begin
            applyStimulus();
            checkOutput("stallValid", outValid, 1);
            checkOutput("stallData", outData, rW[3]);
            checkOutput("stallLast", outLast, 0);
        end
        for (int i = 3; i < 8; i++) begin
            checkOutput("postStallData", outData, rW[i]);
            checkOutput("postStallLast", outLast, (i == 7));
            outReady = 1'b1;
            applyStimulus();
        end
        outReady = 1'b0;
        checkOutput("job2Done", inReady, 1);

        // Job 3: a ninth push overflows and flags an error.
        loadJob(17'h00777, 1'b0);
        pushWords(8, 1'b0);
        checkOutput("noErrAtFull", err, 0);
        mmPush = 1'b1; mmRes = 17'h1ABCD; applyStimulus(); mmPush = 1'b0;
        checkOutput("overflowErr", err, 1);
        mmDone = 1'b1; applyStimulus(); mmDone = 1'b0;
        drainAll();
        checkOutput("errStickyInLoad", err, 1);

        // Job 4: done after only seven pushes.
        loadJob(17'h00888, 1'b1);
        pushWords(7, 1'b0);
        checkOutput("noErrBeforeDone", err, 0);
        mmDone = 1'b1; applyStimulus(); mmDone = 1'b0;
        checkOutput("shortResultErr", err, 1);
        drainAll();

        // Job 5: reset in RUN after three pushes aborts the job.
        loadJob(17'h00999, 1'b1);
        pushWords(3, 1'b0);
        reset = 1'b1; applyStimulus(); reset = 1'b0;
        checkOutput("abortInReady", inReady, 1);
        checkOutput("abortBusy", busy, 0);
        checkOutput("abortOutValid", outValid, 0);
        checkOutput("abortErr", err, 0);
        checkOutput("abortB", mmB, 0);

        // Job 6: normal job after the abort.
        for (int i = 0; i < 8; i++) begin
            bW[i] = 17'h10F00 + 17'(i);
            rW[i] = 17'h1F000 - 17'(i * 'h21);
        end
        loadJob(17'h0ABCD, 1'b0);
        checkOutput("job6B0", mmB, bW[0]);
        pushWords(8, 1'b1);
        checkOutput("job6Err", err, 0);
        drainAll();

        // A multiplier strobe while idle is a protocol error.
        mmBFetch = 1'b1; applyStimulus(); mmBFetch = 1'b0;
        checkOutput("idleStrobeErr", err, 1);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
